// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter with bounded bursts in front of the single-port Data_Memory.
// Define ARB_FIXED_PRIORITY_EN to make port 0 always win contention.
module data_memory_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_i,
  input  logic [1:0]              we_i,
  input  logic [2*ADDR_WIDTH-1:0] addr_i,
  input  logic [2*DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    mem_write_o,
  output logic                    mem_read_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);
  localparam logic [CntW-1:0] OneCnt = CntW'(1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  logic            last_q, last_d;
  logic [1:0]      rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]      rd_gnt;

  // Grant is forced low while reset is held so nothing reaches the memory.
  always_comb begin
    gnt_o = 2'b00;
    if (reset) begin
`ifdef ARB_FIXED_PRIORITY_EN
      if (req_i[0])      gnt_o = 2'b01;
      else if (req_i[1]) gnt_o = 2'b10;
`else
      unique case (state_q)
        StIdle: begin
          if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
          else                gnt_o = req_i;
        end
        StOwn0: begin
          if (req_i[0]) gnt_o = (req_i[1] && burst_cnt_q == MaxCnt) ? 2'b10 : 2'b01;
          else          gnt_o = {req_i[1], 1'b0};
        end
        StOwn1: begin
          if (req_i[1]) gnt_o = (req_i[0] && burst_cnt_q == MaxCnt) ? 2'b01 : 2'b10;
          else          gnt_o = {1'b0, req_i[0]};
        end
        default: gnt_o = 2'b00;
      endcase
`endif
    end
  end

  // Counter keeps climbing only while the same owner is re-granted.
  always_comb begin
    state_d     = StIdle;
    burst_cnt_d = '0;
    last_d      = last_q;
    if (gnt_o[0]) begin
      state_d     = StOwn0;
      last_d      = 1'b0;
      burst_cnt_d = (state_q != StOwn0) ? OneCnt :
                    (burst_cnt_q == MaxCnt) ? MaxCnt : burst_cnt_q + OneCnt;
    end else if (gnt_o[1]) begin
      state_d     = StOwn1;
      last_d      = 1'b1;
      burst_cnt_d = (state_q != StOwn1) ? OneCnt :
                    (burst_cnt_q == MaxCnt) ? MaxCnt : burst_cnt_q + OneCnt;
    end
  end

  assign rd_gnt = gnt_o & ~we_i;

  always_comb begin
    mem_write_o = |(gnt_o & we_i);
    mem_read_o  = |rd_gnt;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt_o[1]) begin
      mem_addr_o  = addr_i[ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata_o = wdata_i[DATA_WIDTH +: DATA_WIDTH];
    end else if (gnt_o[0]) begin
      mem_addr_o  = addr_i[0 +: ADDR_WIDTH];
      mem_wdata_o = wdata_i[0 +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      burst_cnt_q <= '0;
      last_q      <= 1'b1;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
      rvalid_q    <= rd_gnt;
      if (|rd_gnt) rdata_q <= mem_rdata_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter (default round-robin build, MAX_BURST=4).
module tb_data_memory_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_i, we_i;
  logic [2*AW-1:0] addr_i;
  logic [2*DW-1:0] wdata_i;
  logic [1:0]    gnt_o, rvalid_o;
  logic [DW-1:0] rdata_o;
  logic          mem_write_o, mem_read_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  logic [DW-1:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .mem_write_o (mem_write_o),
    .mem_read_o  (mem_read_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Data_Memory stand-in: combinational read, write on the clock edge.
  assign mem_rdata_i = mem[mem_addr_o[7:0]];
  always @(posedge clk) if (mem_write_o) mem[mem_addr_o[7:0]] <= mem_wdata_o;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] gseq [0:8];
    gseq[0] = 2'b01; gseq[1] = 2'b01; gseq[2] = 2'b01; gseq[3] = 2'b01;
    gseq[4] = 2'b10; gseq[5] = 2'b10; gseq[6] = 2'b10; gseq[7] = 2'b10;
    gseq[8] = 2'b01;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;

    // Reset held with both ports requesting reads.
    reset   = 1'b0;
    req_i   = 2'b11;
    we_i    = 2'b00;
    addr_i  = {32'h8, 32'h4};
    wdata_i = '0;
    @(negedge clk);
    chk("rst_gnt", 64'(gnt_o), 64'h0);
    chk("rst_rvalid", 64'(rvalid_o), 64'h0);
    chk("rst_rdata", 64'(rdata_o), 64'h0);
    chk("rst_mem_read", 64'(mem_read_o), 64'h0);
    chk("rst_mem_write", 64'(mem_write_o), 64'h0);
    @(negedge clk);
    chk("rst_rvalid_2", 64'(rvalid_o), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr_o), 64'h0);
    next_cycle();
    reset = 1'b1;

    // Continuous contention: bursts of four, port 0 first.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt_%0d", k), 64'(gnt_o), 64'(gseq[k]));
      chk($sformatf("rr_mem_read_%0d", k), 64'(mem_read_o), 64'h1);
      if (k > 0) begin
        chk($sformatf("rr_rvalid_%0d", k), 64'(rvalid_o), 64'(gseq[k-1]));
        chk($sformatf("rr_rdata_%0d", k), 64'(rdata_o),
            (gseq[k-1] == 2'b01) ? 64'hA000_0004 : 64'hA000_0008);
      end
      next_cycle();
    end

    // Port 1 write, then port 0 reads it back.
    req_i   = 2'b10;
    we_i    = 2'b10;
    addr_i  = {32'h10, 32'h0};
    wdata_i = {32'hCAFE_0001, 32'h0};
    @(negedge clk);
    chk("wr_gnt", 64'(gnt_o), 64'h2);
    chk("wr_mem_write", 64'(mem_write_o), 64'h1);
    chk("wr_mem_read", 64'(mem_read_o), 64'h0);
    chk("wr_mem_addr", 64'(mem_addr_o), 64'h10);
    chk("wr_mem_wdata", 64'(mem_wdata_o), 64'hCAFE_0001);
    chk("wr_prev_rvalid", 64'(rvalid_o), 64'h1);
    next_cycle();
    req_i  = 2'b01;
    we_i   = 2'b00;
    addr_i = {32'h0, 32'h10};
    @(negedge clk);
    chk("rb_gnt", 64'(gnt_o), 64'h1);
    chk("rb_mem_read", 64'(mem_read_o), 64'h1);
    chk("rb_no_rvalid_after_write", 64'(rvalid_o), 64'h0);
    next_cycle();
    req_i = 2'b00;
    @(negedge clk);
    chk("rb_rvalid", 64'(rvalid_o), 64'h1);
    chk("rb_rdata", 64'(rdata_o), 64'hCAFE_0001);
    chk("idle_gnt", 64'(gnt_o), 64'h0);
    chk("idle_mem_addr", 64'(mem_addr_o), 64'h0);
    next_cycle();

    // Port 0 alone streams reads; no forced switch.
    for (int i = 0; i <= 8; i++) begin
      req_i  = (i < 8) ? 2'b01 : 2'b00;
      addr_i = {32'h0, 32'h20 + 32'(i)};
      @(negedge clk);
      chk($sformatf("solo_gnt_%0d", i), 64'(gnt_o), (i < 8) ? 64'h1 : 64'h0);
      if (i > 0) begin
        chk($sformatf("solo_rvalid_%0d", i), 64'(rvalid_o), 64'h1);
        chk($sformatf("solo_rdata_%0d", i), 64'(rdata_o), 64'hA000_0020 + 64'(i - 1));
      end
      next_cycle();
    end
    @(negedge clk);
    chk("solo_rvalid_end", 64'(rvalid_o), 64'h0);
    next_cycle();

    // Port 1 read grant, then reset lands in the following cycle.
    req_i  = 2'b10;
    we_i   = 2'b00;
    addr_i = {32'h30, 32'h0};
    @(negedge clk);
    chk("pre_rst_gnt", 64'(gnt_o), 64'h2);
    next_cycle();
    reset = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(rvalid_o), 64'h0);
    chk("mid_rst_rdata", 64'(rdata_o), 64'h0);
    chk("mid_rst_gnt", 64'(gnt_o), 64'h0);
    next_cycle();
    reset = 1'b1;
    req_i = 2'b11;
    addr_i = {32'h8, 32'h4};
    @(negedge clk);
    chk("post_rst_gnt", 64'(gnt_o), 64'h1);
    chk("post_rst_rvalid", 64'(rvalid_o), 64'h0);
    next_cycle();
    @(negedge clk);
    chk("post_rst_rvalid_2", 64'(rvalid_o), 64'h1);
    chk("post_rst_rdata", 64'(rdata_o), 64'hA000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
